// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage with optional two-entry skid buffer and bubble control masking
module pipe_skid_stage #(
  parameter int WIDTH = 174,
  parameter int CTRLW = 4,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);
  localparam logic [WIDTH-1:0] CMASK = ~({WIDTH{1'b1}} >> CTRLW);
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_fire, out_fire;
  assign in_ready  = (SKID != 0) ? ~skid_v_q : (~main_v_q | out_ready);
  assign out_valid = main_v_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v_q & out_ready;
  assign occ       = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign out_data  = out_valid ? main_q : (main_q & ~CMASK);
  // next state: pop first (skid refills main), then place any accepted payload in the first free slot
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (out_fire && skid_v_q) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (out_fire) begin
      main_v_d = 1'b0;
    end
    if (in_fire && !main_v_d) begin
      main_v_d = 1'b1;
      main_d   = in_data;
    end else if (in_fire && SKID != 0) begin
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end
  // state registers; reset clears valids and payload storage ahead of everything else
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vector table, SKID=0 sequence and randomized queue-model check
module tb_pipe_skid_stage;
  logic       clk = 1'b0;
  logic       reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ir1, ov1, ir0, ov0;
  logic [7:0] od1, od0;
  logic [1:0] occ1, occ0;
  int         tests = 0, fails = 0;
  logic [7:0] q1[$], q0[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(8), .CTRLW(2), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occ(occ1));
  pipe_skid_stage #(.WIDTH(8), .CTRLW(2), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occ(occ0));

  typedef struct {
    logic       rst, fl, iv, ordy;
    logic [7:0] din;
    logic       ov;
    logic [7:0] od, mask;
    logic [1:0] occ;
    logic       ir;
  } vec_t;
  vec_t tbl[25];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, logic [7:0] din,
                              logic ov, logic [7:0] od, logic [7:0] mask, logic [1:0] oc, logic ir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.din = din;
    v.ov = ov; v.od = od; v.mask = mask; v.occ = oc; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q1.delete();
    q0.delete();
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,1,8'h00, 0,8'h00,8'hFF,0,1);
    tbl[1]  = mk(0,0,1,1,8'hC1, 0,8'h00,8'hC0,0,1);
    tbl[2]  = mk(0,0,1,1,8'hC2, 1,8'hC1,8'hFF,1,1);
    tbl[3]  = mk(0,0,1,1,8'hC3, 1,8'hC2,8'hFF,1,1);
    tbl[4]  = mk(0,0,0,1,8'h00, 1,8'hC3,8'hFF,1,1);
    tbl[5]  = mk(0,0,0,1,8'h00, 0,8'h00,8'hC0,0,1);
    tbl[6]  = mk(0,0,1,0,8'hC1, 0,8'h00,8'hC0,0,1);
    tbl[7]  = mk(0,0,1,0,8'hC2, 1,8'hC1,8'hFF,1,1);
    tbl[8]  = mk(0,0,0,0,8'h00, 1,8'hC1,8'hFF,2,0);
    tbl[9]  = mk(0,0,0,1,8'h00, 1,8'hC1,8'hFF,2,0);
    tbl[10] = mk(0,0,0,1,8'h00, 1,8'hC2,8'hFF,1,1);
    tbl[11] = mk(0,0,0,1,8'h00, 0,8'h00,8'hC0,0,1);
    tbl[12] = mk(0,0,1,0,8'hC1, 0,8'h00,8'hC0,0,1);
    tbl[13] = mk(0,0,1,0,8'hC2, 1,8'hC1,8'hFF,1,1);
    tbl[14] = mk(0,1,1,0,8'hFF, 1,8'hC1,8'hFF,2,0);
    tbl[15] = mk(0,0,0,1,8'h00, 0,8'h00,8'hC0,0,1);
    tbl[16] = mk(0,0,0,1,8'h00, 0,8'h00,8'hC0,0,1);
    tbl[17] = mk(0,0,1,0,8'hFF, 0,8'h00,8'hC0,0,1);
    tbl[18] = mk(0,0,0,1,8'h00, 1,8'hFF,8'hFF,1,1);
    tbl[19] = mk(0,0,0,1,8'h00, 0,8'h00,8'hC0,0,1);
    tbl[20] = mk(0,0,1,0,8'hA5, 0,8'h00,8'hC0,0,1);
    tbl[21] = mk(0,0,1,0,8'h5A, 1,8'hA5,8'hFF,1,1);
    tbl[22] = mk(1,1,0,0,8'h00, 1,8'hA5,8'hFF,2,0);
    tbl[23] = mk(0,0,0,1,8'h00, 0,8'h00,8'hFF,0,1);
    tbl[24] = mk(0,0,0,1,8'h00, 0,8'h00,8'hFF,0,1);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; in_data = tbl[i].din;
      #1;
      chk($sformatf("vec%0d.out_valid", i), {7'd0, ov1}, {7'd0, tbl[i].ov});
      chk($sformatf("vec%0d.out_data", i), od1 & tbl[i].mask, tbl[i].od);
      chk($sformatf("vec%0d.occ", i), {6'd0, occ1}, {6'd0, tbl[i].occ});
      chk($sformatf("vec%0d.in_ready", i), {7'd0, ir1}, {7'd0, tbl[i].ir});
      @(posedge clk);
      @(negedge clk);
    end

    do_reset();
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    #1 chk("s0.ready_empty", {7'd0, ir0}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("s0.ready_stall", {7'd0, ir0}, 8'd0);
    chk("s0.valid_held", {7'd0, ov0}, 8'd1);
    out_ready = 1'b1;
    #1 chk("s0.ready_follow_hi", {7'd0, ir0}, 8'd1);
    out_ready = 1'b0;
    #1 chk("s0.ready_follow_lo", {7'd0, ir0}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h20 + 8'(i);
      #1;
      chk($sformatf("s0.stream%0d.data", i), od0, (i == 0) ? 8'h11 : 8'h20 + 8'(i - 1));
      chk($sformatf("s0.stream%0d.occ", i), {6'd0, occ0}, 8'd1);
      chk($sformatf("s0.stream%0d.ready", i), {7'd0, ir0}, 8'd1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 chk("s0.stream_last", od0, 8'h25);

    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic e_ir1, e_ir0, fi1, fo1, fi0, fo0;
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 9) < 6;
      in_data = 8'($urandom);
      #1;
      e_ir1 = q1.size() < 2;
      e_ir0 = (q0.size() == 0) || out_ready;
      chk("rnd1.in_ready", {7'd0, ir1}, {7'd0, e_ir1});
      chk("rnd1.occ", {6'd0, occ1}, 8'(q1.size()));
      chk("rnd1.out_valid", {7'd0, ov1}, {7'd0, q1.size() > 0});
      chk("rnd1.out_data", q1.size() > 0 ? od1 : od1 & 8'hC0, q1.size() > 0 ? q1[0] : 8'h00);
      chk("rnd0.in_ready", {7'd0, ir0}, {7'd0, e_ir0});
      chk("rnd0.occ", {6'd0, occ0}, 8'(q0.size()));
      chk("rnd0.out_valid", {7'd0, ov0}, {7'd0, q0.size() > 0});
      chk("rnd0.out_data", q0.size() > 0 ? od0 : od0 & 8'hC0, q0.size() > 0 ? q0[0] : 8'h00);
      fi1 = in_valid && e_ir1; fo1 = (q1.size() > 0) && out_ready;
      fi0 = in_valid && e_ir0; fo0 = (q0.size() > 0) && out_ready;
      @(posedge clk);
      if (reset || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (fo1) void'(q1.pop_front());
        if (fi1) q1.push_back(in_data);
        if (fo0) void'(q0.pop_front());
        if (fi0) q0.push_back(in_data);
      end
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 174, meaning total payload width in bits (control + data fields concatenated, control in MSBs).
REQ-002 The block SHALL have parameter CTRLW, default 4, meaning the number of MSB payload bits treated as write-enable/control bits; 0 <= CTRLW <= WIDTH.
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 selects a two-entry skid buffer and 0 selects a single-entry register.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1, meaning a synchronous pipeline kill.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the upstream payload is valid.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the stage accepts a payload this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH, meaning the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_data holds a live entry.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream consumes out_data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH, meaning the oldest held payload.
REQ-013 The block SHALL have port occ, output, 2, meaning the number of entries held (0..2; max 1 when SKID=0).

Function
REQ-014 The block SHALL complete an input transfer on a cycle with in_valid & in_ready, and an output transfer on a cycle with out_valid & out_ready.
REQ-015 The block SHALL present an accepted payload on out_data with out_valid=1 exactly one cycle after acceptance when the stage was empty, so latency is 1 and throughput is 1 per cycle with out_ready held high.
REQ-016 The block SHALL deliver payloads in acceptance order with no loss or duplication.
REQ-017 With SKID=1, the block SHALL drive in_ready = NOT skid_valid from a register, with no combinational path from out_ready to in_ready.
REQ-018 With SKID=1, a payload accepted while main is full and out_ready=0 SHALL be stored in the skid entry, and in_ready SHALL be 0 from the next cycle.
REQ-019 With SKID=1, on an output transfer while skid is full, the skid entry SHALL move to main on the same edge and in_ready SHALL return to 1 on the next cycle.
REQ-020 With SKID=1, simultaneous input and output transfers with only main full SHALL replace main with in_data, leaving occ at 1.
REQ-021 With SKID=0, the block SHALL drive in_ready = NOT out_valid OR out_ready combinationally, and simultaneous input and output transfers SHALL replace the entry.
REQ-022 The block SHALL force out_data[WIDTH-1 : WIDTH-CTRLW] to 0 whenever out_valid=0, so a bubble can never assert a register, hi/lo, or cp0 write; the remaining bits pass unmasked.
REQ-023 The block SHALL treat flush=1 as clearing both entry valid bits at the clock edge, discarding any input accepted in that cycle; occ=0 and out_valid=0 the next cycle.
REQ-024 During a flush cycle, the block SHALL keep in_ready at its normal value so upstream handshakes complete, but the payload SHALL be dropped.
REQ-025 The block SHALL update occ to reflect the post-edge entry count every cycle; it SHALL never exceed 2 (SKID=1) or 1 (SKID=0).
REQ-026 The block SHALL ignore in_data when in_valid=0 and leave out_data payload bits unchanged while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL clear all valid bits and payload storage to 0; reset SHALL take priority over flush and all transfers.
REQ-028 In the cycle after reset, the block SHALL output out_valid=0, out_data=0, occ=0, and in_ready=1.
REQ-029 The block SHALL discard any entries held when reset asserts mid-stream, and none SHALL appear after reset deasserts.

Verification
REQ-030 The bench SHALL check, with WIDTH=8, CTRLW=2, SKID=1, and out_ready=1, that streaming 0xC1,0xC2,0xC3 on consecutive cycles produces out_data 0xC1,0xC2,0xC3 one cycle later each, with occ=1 throughout.
REQ-031 The bench SHALL check that with out_ready=0, accepting 0xC1 and then 0xC2 gives occ=2 and in_ready=0; raising out_ready then yields 0xC1 and then 0xC2, with in_ready=1 one cycle after the first pop.
REQ-032 The bench SHALL check that asserting flush with occ=2 and in_valid=1 (0xFF) gives out_valid=0, occ=0, and out_data=0x00 or 0x3F-masked, with 0xFF never appearing.
REQ-033 The bench SHALL check that with out_valid=0 and stale storage 0xFF, out_data[7:6] reads 00.
REQ-034 The bench SHALL check, with SKID=0 and out_valid=1, that toggling out_ready changes in_ready in the same cycle, and that back-to-back accept+pop sustains 1 payload per cycle.
REQ-035 The bench SHALL check that asserting reset together with flush while occ=2 gives all outputs 0 and in_ready=1 the next cycle, and that no pre-reset payload emerges afterwards.
